b_arb: RTL and testbench

B_ARB -- requirements
Module: b_arb

---
 rtl/b_arb_pkg.sv | 19 +
 rtl/b_arb_rr.sv | 22 ++
 rtl/b_arb.sv | 133 +++++++++++++
 tb/tb_b_arb.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b_arb_pkg.sv
// Shared types and widths for the two-requester burst arbiter b_arb.
package b_arb_pkg;

    localparam int A_W   = 14;
    localparam int C_W   = 135;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_C = 2'd2
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_C = 1'b1
    } src_t;

endpackage

// File: rtl/b_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the pointer.
module b_arb_rr
    import b_arb_pkg::*;
(
    input  logic a_req,
    input  logic c_req,
    input  src_t ptr,
    output logic pick_valid,
    output src_t pick
);

    always_comb begin
        pick_valid = a_req || c_req;
        pick       = SRC_A;
        if (a_req && c_req) begin
            pick = ptr;
        end else if (c_req) begin
            pick = SRC_C;
        end
    end

endmodule

// File: rtl/b_arb.sv
// Burst-limited arbiter muxing requesters A and C onto shared resource B through a one-deep output register.
// Optional per-source handshake counters a_cnt/c_cnt are built when B_ARB_STATS_EN is defined.
module b_arb
    import b_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [A_W-1:0]   a_data,
    output logic             a_gnt,
    input  logic             c_req,
    input  logic [C_W-1:0]   c_data,
    output logic             c_gnt,
    output logic             b_valid,
    output logic [C_W-1:0]   b_data,
    output logic             b_src,
    input  logic             b_ready,
    output logic             b_busy
`ifdef B_ARB_STATS_EN
    ,
    output logic [15:0]      a_cnt,
    output logic [15:0]      c_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state;
    src_t             ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_after;
    logic             slot_free;
    logic             a_xfer;
    logic             c_xfer;
    logic             xfer;
    logic             own_req;
    logic             other_req;
    logic             pick_valid;
    src_t             pick;

    assign slot_free = !b_valid || b_ready;
    assign a_gnt     = (state == OWN_A) && slot_free;
    assign c_gnt     = (state == OWN_C) && slot_free;
    assign a_xfer    = a_req && a_gnt;
    assign c_xfer    = c_req && c_gnt;
    assign xfer      = a_xfer || c_xfer;
    assign own_req   = (state == OWN_A) ? a_req : c_req;
    assign other_req = (state == OWN_A) ? c_req : a_req;

    // Counting the beat being granted right now lets the yield land on the MAX_BURST-th beat, not one later.
    assign cnt_after = (xfer && (burst_cnt != MAX_CNT)) ? burst_cnt + CNT_W'(1) : burst_cnt;

    b_arb_rr u_rr (
        .a_req      (a_req),
        .c_req      (c_req),
        .ptr        (ptr),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // Ownership only moves when the output slot can take a beat, so a stalled B freezes the arbiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= SRC_A;
            burst_cnt <= '0;
            b_busy    <= 1'b0;
        end else if (slot_free) begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= (pick == SRC_A) ? OWN_A : OWN_C;
                        ptr       <= (pick == SRC_A) ? SRC_C : SRC_A;
                        burst_cnt <= '0;
                        b_busy    <= 1'b1;
                    end
                end
                OWN_A, OWN_C: begin
                    if (!own_req || ((cnt_after == MAX_CNT) && other_req)) begin
                        burst_cnt <= '0;
                        if (other_req) begin
                            state  <= (state == OWN_A) ? OWN_C : OWN_A;
                            ptr    <= (state == OWN_A) ? SRC_A : SRC_C;
                            b_busy <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            b_busy <= 1'b0;
                        end
                    end else begin
                        burst_cnt <= cnt_after;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                    b_busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_data  <= '0;
            b_src   <= SRC_A;
        end else if (xfer) begin
            b_valid <= 1'b1;
            b_src   <= a_xfer ? SRC_A : SRC_C;
            b_data  <= a_xfer ? {{(C_W-A_W){1'b0}}, a_data} : c_data;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

`ifdef B_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            c_cnt <= '0;
        end else if (b_valid && b_ready) begin
            if (b_src == SRC_A) begin
                a_cnt <= a_cnt + 16'd1;
            end else begin
                c_cnt <= c_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_b_arb.sv
// Self-checking bench for b_arb: directed vector table, burst/stall/reset sequences, and random traffic against a reference model.
module tb_b_arb;

    localparam int MAX = 4;

    logic         clk;
    logic         rst_n;
    logic         a_req;
    logic [13:0]  a_data;
    logic         a_gnt;
    logic         c_req;
    logic [134:0] c_data;
    logic         c_gnt;
    logic         b_valid;
    logic [134:0] b_data;
    logic         b_src;
    logic         b_ready;
    logic         b_busy;
`ifdef B_ARB_STATS_EN
    logic [15:0]  a_cnt;
    logic [15:0]  c_cnt;
`endif

    int total;
    int bad;

    // Reference model: owner -1 = nobody, 0 = A, 1 = C; fav is the requester that wins a tie.
    int           m_owner;
    int           m_fav;
    int           m_run;
    bit           m_valid;
    logic [134:0] m_data;
    bit           m_src;
    int           m_acnt;
    int           m_ccnt;

    b_arb #(.MAX_BURST(MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_data  (a_data),
        .a_gnt   (a_gnt),
        .c_req   (c_req),
        .c_data  (c_data),
        .c_gnt   (c_gnt),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_src   (b_src),
        .b_ready (b_ready),
        .b_busy  (b_busy)
`ifdef B_ARB_STATS_EN
        ,
        .a_cnt   (a_cnt),
        .c_cnt   (c_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         a_req;
        logic         c_req;
        logic         b_ready;
        logic [13:0]  a_data;
        logic [134:0] c_data;
        logic         e_a_gnt;
        logic         e_c_gnt;
        logic         e_valid;
        logic         e_src;
        logic         e_busy;
        logic [134:0] e_data;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [134:0] rand135();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[134:0];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_fav   = 0;
        m_run   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 1'b0;
        m_acnt  = 0;
        m_ccnt  = 0;
    endtask

    // Advances the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit slot, xa, xc, mine, oth;
        int run_after;
        slot = !m_valid || b_ready;
        xa   = (m_owner == 0) && slot && a_req;
        xc   = (m_owner == 1) && slot && c_req;
        if (m_valid && b_ready) begin
            if (m_src == 1'b0) m_acnt++;
            else               m_ccnt++;
        end
        if (xa) begin
            m_valid = 1'b1; m_data = {121'b0, a_data}; m_src = 1'b0;
        end else if (xc) begin
            m_valid = 1'b1; m_data = c_data; m_src = 1'b1;
        end else if (b_ready) begin
            m_valid = 1'b0;
        end
        if (slot) begin
            if (m_owner < 0) begin
                if (a_req || c_req) begin
                    m_owner = (a_req && c_req) ? m_fav : (a_req ? 0 : 1);
                    m_fav   = 1 - m_owner;
                    m_run   = 0;
                end
            end else begin
                mine      = (m_owner == 0) ? a_req : c_req;
                oth       = (m_owner == 0) ? c_req : a_req;
                run_after = m_run + ((xa || xc) ? 1 : 0);
                if (run_after > MAX) run_after = MAX;
                if (!mine || (run_after == MAX && oth)) begin
                    if (oth) begin
                        m_fav   = m_owner;
                        m_owner = 1 - m_owner;
                    end else begin
                        m_owner = -1;
                    end
                    m_run = 0;
                end else begin
                    m_run = run_after;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic a, input logic c, input logic r,
                                 input logic [13:0] ad, input logic [134:0] cd);
        a_req   = a;
        c_req   = c;
        b_ready = r;
        a_data  = ad;
        c_data  = cd;
    endtask

    task automatic checkOutput();
        bit slot;
        slot = !m_valid || b_ready;
        chk("m_a_gnt", a_gnt, (m_owner == 0) && slot);
        chk("m_c_gnt", c_gnt, (m_owner == 1) && slot);
        chk("m_b_valid", b_valid, m_valid);
        chk("m_b_busy", b_busy, m_owner >= 0);
        if (m_valid) begin
            chk("m_b_src", b_src, m_src);
            chk("m_b_data", b_data, m_data);
        end
`ifdef B_ARB_STATS_EN
        chk("m_a_cnt", a_cnt, 135'(m_acnt % 65536));
        chk("m_c_cnt", c_cnt, 135'(m_ccnt % 65536));
`endif
    endtask

    task automatic cycle(input logic a, input logic c, input logic r,
                         input logic [13:0] ad, input logic [134:0] cd);
        applyStimulus(a, c, r, ad, cd);
        #1;
        checkOutput();
        model_step();
        @(negedge clk);
    endtask

    // Asserts reset right after a falling edge and checks the outputs clear without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_a_gnt", a_gnt, 1'b0);
        chk("rst_c_gnt", c_gnt, 1'b0);
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_b_data", b_data, '0);
        chk("rst_b_src", b_src, 1'b0);
        chk("rst_b_busy", b_busy, 1'b0);
`ifdef B_ARB_STATS_EN
        chk("rst_a_cnt", a_cnt, '0);
        chk("rst_c_cnt", c_cnt, '0);
`endif
        model_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [134:0] C1 = {7'h5A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    localparam logic [134:0] C2 = {7'h21, 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0};

    initial begin
        int beats;
        int guard;
        bit ok_src;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();

        //                a  c  rdy a_data    c_data  a_gnt c_gnt valid src busy data
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 14'h1ABC, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 14'h1ABC, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 14'h0000, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 135'h1ABC};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 14'h0000, C1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 14'h0000, C1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 14'h0000, C2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 14'h0000, C2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 14'h0005, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C2};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 14'h0005, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 14'h0000, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 135'h5};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 14'h0000, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].a_req, tbl[i].c_req, tbl[i].b_ready, tbl[i].a_data, tbl[i].c_data);
            #1;
            chk($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].e_a_gnt);
            chk($sformatf("tbl%0d_c_gnt", i), c_gnt, tbl[i].e_c_gnt);
            chk($sformatf("tbl%0d_b_valid", i), b_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_b_busy", i), b_busy, tbl[i].e_busy);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_b_src", i), b_src, tbl[i].e_src);
                chk($sformatf("tbl%0d_b_data", i), b_data, tbl[i].e_data);
            end
            checkOutput();
            model_step();
            @(negedge clk);
        end

        // Both requesting from reset: A first, then 4-beat bursts alternating with no bubbles.
        do_reset();
        beats  = 0;
        ok_src = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 14'(i), rand135());
            #1;
            if (b_valid) begin
                if (b_src !== 1'((beats / MAX) % 2)) ok_src = 1'b0;
                beats++;
            end
            checkOutput();
            model_step();
            @(negedge clk);
        end
        chk("burst_beats", 135'(beats), 135'd38);
        chk("burst_order", ok_src, 1'b1);

        // C alone for 10 beats never yields and never loses the grant.
        do_reset();
        beats = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, (i <= 10), 1'b1, '0, rand135());
            if (b_valid && b_src) beats++;
        end
        chk("c_only_beats", 135'(beats), 135'd10);

        // B stalls with an A beat held while A drops its request and C waits.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 14'h0111, C1);
        cycle(1'b1, 1'b1, 1'b1, 14'h0111, C1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i < 2), 1'b1, 1'b0, 14'h0222, C2);
            #1;
            chk("stall_b_data", b_data, 135'h111);
            chk("stall_b_src", b_src, 1'b0);
            chk("stall_a_gnt", a_gnt, 1'b0);
            chk("stall_c_gnt", c_gnt, 1'b0);
            checkOutput();
            model_step();
            @(negedge clk);
        end
        cycle(1'b0, 1'b1, 1'b1, '0, C2);
        cycle(1'b0, 1'b1, 1'b1, '0, C2);
        cycle(1'b0, 1'b0, 1'b1, '0, '0);

        // Reset in the middle of a C burst, then a tie must go to A.
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, '0, C1);
        cycle(1'b0, 1'b1, 1'b1, '0, C2);
        cycle(1'b0, 1'b1, 1'b0, '0, C1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, C2);
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 14'h0033, C1);
        applyStimulus(1'b1, 1'b1, 1'b1, 14'h0033, C1);
        #1;
        chk("post_rst_a_gnt", a_gnt, 1'b1);
        chk("post_rst_c_gnt", c_gnt, 1'b0);
        checkOutput();
        model_step();
        @(negedge clk);

        // Random traffic, biased so bursts and stalls both happen often.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 7), 14'($urandom), rand135());
        end

`ifdef B_ARB_STATS_EN
        // 65537 A handshakes wrap a_cnt to 1.
        do_reset();
        guard = 0;
        while (m_acnt < 65537 && guard < 70000) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 14'(guard), '0);
            model_step();
            @(negedge clk);
            guard++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        #1;
        chk("wrap_bound", 135'(m_acnt), 135'd65537);
        chk("wrap_a_cnt", a_cnt, 135'd1);
        chk("wrap_c_cnt", c_cnt, 135'd0);
`else
        guard = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
